cpu_regfile_client: RTL
=======================

# cpu_regfile_client

Requester-side sequencer for the tag-handshake register file. It converts a decode-stage operand-read request and a writeback-stage write request, both valid/ready, into the register file's toggle-tag protocol. The protocol: a changed 8-bit tag triggers one read or write on the register file's next clock. The block captures the returned operands and presents them to execute, forwarding a same-cycle writeback and forcing x0 reads to zero.

## Interface

- TAG_W, 8: tag width; must match the register file.
- i_clock  in  1  single clock, rising edge.
- i_reset  in  1  asynchronous, active-low reset.
- i_rd_valid  in  1  decode requests an operand read.
- o_rd_ready  out  1  read request accepted when high with i_rd_valid.
- i_rs1_idx, i_rs2_idx  in  5 each  source register indices.
- o_op_valid  out  1  o_op1/o_op2 hold valid operands.
- i_op_ready  in  1  execute consumes operands.
- o_op1, o_op2  out  32 each  operand values.
- i_wb_valid  in  1  writeback request.
- o_wb_ready  out  1  writeback accepted; high whenever out of reset.
- i_wb_rd_idx  in  5  destination index.
- i_wb_data  in  32  write data.
- o_read_tag  out  TAG_W  register-file read tag.
- o_read_rs1_idx, o_read_rs2_idx  out  5 each  latched read indices.
- i_rs1, i_rs2  in  32 each  register-file read data.
- o_write_tag  out  TAG_W  register-file write tag.
- o_write_rd_idx  out  5  latched write index.
- o_rd  out  32  latched write data.

## Operation

- Read FSM states: IDLE, WAIT1, WAIT2, VALID.
  - IDLE: o_rd_ready=1. On i_rd_valid, the block:
    - increments o_read_tag (mod 2^TAG_W);
    - latches both indices to o_read_rs*_idx;
    - records the indices internally;
    - moves to WAIT1.
  - WAIT1 → WAIT2 unconditionally. During this cycle the register file loads its outputs.
  - WAIT2: capture i_rs1/i_rs2 into o_op1/o_op2 with forwarding and x0 rules applied, set o_op_valid=1, go to VALID.
  - VALID: hold operands stable.
    - On i_op_ready, clear o_op_valid.
    - o_rd_ready = i_op_ready. If i_rd_valid is also high, accept the new request and go to WAIT1 directly, with no IDLE bubble. Otherwise go to IDLE.
- Write path, no FSM: on i_wb_valid, the block:
  - increments o_write_tag;
  - latches o_write_rd_idx and o_rd;
  - accepts every cycle, so back-to-back writes give one tag change per cycle.
- Forwarding: if a write is accepted in the same cycle as a read, the register file would return the stale value. The block therefore records that write's index and data. In WAIT2, any operand whose index equals the recorded index, and is non-zero, takes the recorded data instead of i_rs*.
  - Writes accepted one or more cycles before the read need no forwarding.
  - Writes accepted during WAIT1/WAIT2 land after the read sample and must not be forwarded.
- x0: each operand is forced to 0 when its own index is 0. This is independent of i_rs* and of forwarding; rs2 is judged by rs2's index, not rs1's.
- Writes to x0 are still forwarded to the register file (tag increments); reads of x0 are masked here.
- Tag wrap 2^TAG_W−1 → 0 counts as a change; no special case.

## Timing

- Reset values (async, i_reset low):
  - o_read_tag=0, o_write_tag=0, so they match the register file's reset tags.
  - All index, data and operand outputs = 0.
  - o_op_valid=0, FSM=IDLE, forwarding record invalid.
  - o_rd_ready=0 and o_wb_ready=0 while in reset.
- Read latency: request accepted at edge N → o_op_valid high after edge N+2. Throughput is one read per 3 cycles when execute is always ready.
- Write: accepted at edge M → tag/index/data change after M; the register file updates at M+1.
- Operands and o_op_valid are stable in VALID until consumed.
- Reset asserted mid-read drops o_op_valid immediately. There is no resumption; decode must re-request.

## Test plan

- Reset, then write x5=0x1234 and, two cycles later, read rs1=5, rs2=0 → o_read_tag 0→1, o_write_tag 0→1, o_op1=0x1234, o_op2=0, o_op_valid after 2 edges.
- Same-cycle write x7=0xDEADBEEF with read rs1=7, rs2=7 → both operands 0xDEADBEEF despite stale i_rs*.
- Write x3=0xAA during WAIT1 with a read of rs1=3 → o_op1 equals the register file's old value, not 0xAA.
- Hold i_op_ready=0 for 5 cycles in VALID, then pulse it with i_rd_valid=1 → operands constant throughout; the next request is accepted in the same cycle and the FSM goes to WAIT1.
- 300 consecutive writes → o_write_tag wraps 255→0 and every write lands, checked by reading back.
- Assert i_reset in WAIT2 → o_op_valid=0, tags=0, FSM IDLE; a fresh read completes normally.

Source files
------------

// File: rtl/cpu_regfile_client.sv
// Requester-side sequencer for the toggle-tag register file: turns valid/ready operand reads and
// writebacks into tag changes, captures returned operands, forwards same-cycle writes, masks x0.
module cpu_regfile_client #(
  parameter int unsigned TAG_W = 8
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_rd_valid,
  output logic             o_rd_ready,
  input  logic [4:0]       i_rs1_idx,
  input  logic [4:0]       i_rs2_idx,
  output logic             o_op_valid,
  input  logic             i_op_ready,
  output logic [31:0]      o_op1,
  output logic [31:0]      o_op2,
  input  logic             i_wb_valid,
  output logic             o_wb_ready,
  input  logic [4:0]       i_wb_rd_idx,
  input  logic [31:0]      i_wb_data,
  output logic [TAG_W-1:0] o_read_tag,
  output logic [4:0]       o_read_rs1_idx,
  output logic [4:0]       o_read_rs2_idx,
  input  logic [31:0]      i_rs1,
  input  logic [31:0]      i_rs2,
  output logic [TAG_W-1:0] o_write_tag,
  output logic [4:0]       o_write_rd_idx,
  output logic [31:0]      o_rd
);

  typedef enum logic [1:0] {StIdle, StWait1, StWait2, StValid} state_e;

  localparam logic [TAG_W-1:0] TagOne = {{(TAG_W-1){1'b0}}, 1'b1};

  state_e           state_q;
  logic [TAG_W-1:0] read_tag_q, write_tag_q;
  logic [4:0]       rs1_q, rs2_q, wr_idx_q;
  logic [31:0]      wr_data_q, op1_q, op2_q;
  logic             op_valid_q;
  logic             fwd_valid_q;
  logic [4:0]       fwd_idx_q;
  logic [31:0]      fwd_data_q;
  logic             rd_ready, rd_accept;
  logic [31:0]      sel_op1, sel_op2;

  assign rd_ready  = i_reset & ((state_q == StIdle) | ((state_q == StValid) & i_op_ready));
  assign rd_accept = i_rd_valid & rd_ready;

  // The recorded write was issued alongside the read, so the register file returns stale data.
  always_comb begin
    sel_op1 = i_rs1;
    sel_op2 = i_rs2;
    if (fwd_valid_q && (fwd_idx_q == rs1_q)) sel_op1 = fwd_data_q;
    if (fwd_valid_q && (fwd_idx_q == rs2_q)) sel_op2 = fwd_data_q;
    if (rs1_q == 5'd0) sel_op1 = '0;
    if (rs2_q == 5'd0) sel_op2 = '0;
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q     <= StIdle;
      read_tag_q  <= '0;
      write_tag_q <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      wr_idx_q    <= '0;
      wr_data_q   <= '0;
      op1_q       <= '0;
      op2_q       <= '0;
      op_valid_q  <= 1'b0;
      fwd_valid_q <= 1'b0;
      fwd_idx_q   <= '0;
      fwd_data_q  <= '0;
    end else begin
      if (i_wb_valid) begin
        write_tag_q <= write_tag_q + TagOne;
        wr_idx_q    <= i_wb_rd_idx;
        wr_data_q   <= i_wb_data;
      end
      if (rd_accept) begin
        read_tag_q  <= read_tag_q + TagOne;
        rs1_q       <= i_rs1_idx;
        rs2_q       <= i_rs2_idx;
        fwd_valid_q <= i_wb_valid;
        fwd_idx_q   <= i_wb_rd_idx;
        fwd_data_q  <= i_wb_data;
      end
      unique case (state_q)
        StIdle: begin
          if (rd_accept) state_q <= StWait1;
        end
        StWait1: begin
          state_q <= StWait2;
        end
        StWait2: begin
          op1_q      <= sel_op1;
          op2_q      <= sel_op2;
          op_valid_q <= 1'b1;
          state_q    <= StValid;
        end
        StValid: begin
          if (i_op_ready) begin
            op_valid_q <= 1'b0;
            state_q    <= i_rd_valid ? StWait1 : StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign o_rd_ready     = rd_ready;
  assign o_wb_ready     = i_reset;
  assign o_op_valid     = op_valid_q;
  assign o_op1          = op1_q;
  assign o_op2          = op2_q;
  assign o_read_tag     = read_tag_q;
  assign o_read_rs1_idx = rs1_q;
  assign o_read_rs2_idx = rs2_q;
  assign o_write_tag    = write_tag_q;
  assign o_write_rd_idx = wr_idx_q;
  assign o_rd           = wr_data_q;

endmodule
